// File: rtl/keypad_encoder.sv
// Scans a 4x4 active-low keypad, debounces whole scan frames and drives a key code plus
// level pressed flag. Optional auto-repeat is enabled by defining KEYPAD_REPEAT_EN.
module keypad_encoder #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100
) (
    input  logic       clock,
    input  logic       reset,
    output logic [3:0] col,
    input  logic [3:0] row,
    output logic [3:0] button,
    output logic       is_pressed
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {IDLE, PRESS_PEND, HELD, RELEASE_PEND} state_t;

    state_t           state, state_next;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic             sample, frame_end;
    logic [1:0]       acc_hits, frame_hits;
    logic [3:0]       acc_key, frame_key, col_key;
    logic [2:0]       row_hits;
    logic             frame_none, frame_single, frame_multi;
    logic [3:0]       cand, cand_next, button_next;
    logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
    logic             held_now, held_next, pressed_next, rep_fire;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'hF;  4'hD: code = 4'h0;  4'hE: code = 4'hE;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    assign sample    = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign frame_end = sample && (col_idx == 2'd3);
    assign col       = ~(4'b0001 << col_idx);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            col_idx <= 2'd0;
        end else if (sample) begin
            div_cnt <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Contacts are summed across the frame (saturating at 2) so MULTI spans columns too.
    always_comb begin
        row_hits = 3'd0;
        col_key  = 4'h0;
        for (int r = 3; r >= 0; r--) begin
            if (!row[r]) begin
                row_hits = row_hits + 3'd1;
                col_key  = key_map(2'(r), col_idx);
            end
        end
        frame_hits = ((3'(acc_hits) + row_hits) >= 3'd2) ? 2'd2 : 2'(3'(acc_hits) + row_hits);
        frame_key  = (acc_hits == 2'd0) ? col_key : acc_key;
    end

    assign frame_none   = (frame_hits == 2'd0);
    assign frame_single = (frame_hits == 2'd1);
    assign frame_multi  = (frame_hits == 2'd2);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_hits <= 2'd0;
            acc_key  <= 4'h0;
        end else if (frame_end) begin
            acc_hits <= 2'd0;
            acc_key  <= 4'h0;
        end else if (sample) begin
            acc_hits <= frame_hits;
            acc_key  <= frame_key;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cand       <= 4'h0;
            cnt        <= '0;
            button     <= 4'h0;
            is_pressed <= 1'b0;
        end else begin
            state      <= state_next;
            cand       <= cand_next;
            cnt        <= cnt_next;
            button     <= button_next;
            is_pressed <= pressed_next;
        end
    end

    assign cnt_inc = (cnt == CNT_W'(DEBOUNCE_SCANS)) ? cnt : cnt + CNT_W'(1);

    always_comb begin
        state_next  = state;
        cand_next   = cand;
        cnt_next    = cnt;
        button_next = button;
        if (frame_end && !frame_multi) begin
            unique case (state)
                IDLE: begin
                    if (frame_single) begin
                        cand_next = frame_key;
                        cnt_next  = CNT_W'(1);
                        if (DEBOUNCE_SCANS <= 1) begin
                            button_next = frame_key;
                            state_next  = HELD;
                        end else begin
                            state_next  = PRESS_PEND;
                        end
                    end
                end
                PRESS_PEND: begin
                    if (frame_none) begin
                        state_next = IDLE;
                    end else if (frame_key == cand) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                            button_next = cand;
                            state_next  = HELD;
                        end
                    end else begin
                        cand_next = frame_key;
                        cnt_next  = CNT_W'(1);
                    end
                end
                HELD: begin
                    if (frame_none || frame_key != button) begin
                        cnt_next   = CNT_W'(1);
                        state_next = (DEBOUNCE_SCANS <= 1) ? IDLE : RELEASE_PEND;
                    end
                end
                RELEASE_PEND: begin
                    if (frame_single && frame_key == button) begin
                        state_next = HELD;
                    end else begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == CNT_W'(DEBOUNCE_SCANS))
                            state_next = IDLE;
                    end
                end
            endcase
        end
    end

    // The flag rises one cycle after acceptance but falls on the releasing frame end itself.
    always_comb begin
        held_now     = (state == HELD) || (state == RELEASE_PEND);
        held_next    = (state_next == HELD) || (state_next == RELEASE_PEND);
        pressed_next = held_now && held_next && !rep_fire;
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt, rep_inc;
    logic             rep_phase, rep_step;

    assign rep_step = frame_end && (state == HELD) && frame_single && (frame_key == button);
    assign rep_inc  = rep_cnt + REP_W'(1);
    assign rep_fire = rep_step &&
                      (rep_inc == (rep_phase ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else if (state_next == IDLE) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else if (rep_fire) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b1;
        end else if (rep_step) begin
            rep_cnt   <= rep_inc;
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = REPEAT_DELAY[0] ^ REPEAT_RATE[0];
    assign rep_fire          = 1'b0;
`endif
endmodule
